// File: rtl/lightcube_pkg.sv
// Shared constants and the loader state type for the LED cube frame path.
package lightcube_pkg;

    localparam int CUBE_ROWS = 64;
    localparam int ROW_BITS  = 8;
    localparam int ADDR_BITS = 6;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } loader_state_t;

endpackage

// File: rtl/cube_frame_bank.sv
// Double-buffered cube image: writes go to the back bank, swap flips which
// bank is shown, so a half-written frame is never on the output.
module cube_frame_bank
    import lightcube_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [ROW_BITS-1:0]  wr_data,
    input  logic                 wr_en,
    input  logic                 swap,
    output logic [ROW_BITS-1:0]  frame_cube [CUBE_ROWS]
);

    logic [ROW_BITS-1:0] bank0 [CUBE_ROWS];
    logic [ROW_BITS-1:0] bank1 [CUBE_ROWS];
    logic                sel;   // 0: bank0 is front, 1: bank1 is front

    // Bank storage and front-bank select; writes always land in the back bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= 1'b0;
            for (int i = 0; i < CUBE_ROWS; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                if (sel) begin
                    bank0[wr_addr] <= wr_data;
                end else begin
                    bank1[wr_addr] <= wr_data;
                end
            end
            if (swap) begin
                sel <= ~sel;
            end
        end
    end

    // Front-bank read-out.
    always_comb begin
        for (int i = 0; i < CUBE_ROWS; i++) begin
            frame_cube[i] = sel ? bank1[i] : bank0[i];
        end
    end

endmodule

// File: rtl/cube_frame_loader.sv
// Byte-stream frame loader for the LED cube: HEADER, 64 row bytes, XOR
// checksum. A good frame is swapped to the front bank; a bad or stalled
// frame is dropped with a frame_err pulse.
//
// Handshake: a byte is consumed on a rising edge only when in_valid and
// in_ready are both 1; the source may hold in_valid high, and in_ready is
// low only during the one-cycle COMMIT and while rst is high.
module cube_frame_loader
    import lightcube_pkg::*;
#(
    parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ROW_BITS-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ROW_BITS-1:0] frame_cube [CUBE_ROWS],
    output logic                frame_done,
    output logic                frame_err
);

    loader_state_t        state, state_next;
    logic [ADDR_BITS-1:0] idx, idx_next;
    logic [ROW_BITS-1:0]  acc, acc_next;
    logic [15:0]          tmo, tmo_next;
    logic                 done_next, err_next;
    logic                 wr_en, swap;
    logic                 accept, tmo_hit;

    assign in_ready = !rst && (state != COMMIT);
    assign accept   = in_valid && in_ready;
    assign tmo_hit  = (tmo == TIMEOUT_CYCLES - 16'd1);

    // State, index, checksum, idle counter and the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            tmo        <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            acc        <= acc_next;
            tmo        <= tmo_next;
            frame_done <= done_next;
            frame_err  <= err_next;
        end
    end

    // Frame parser: next state, back-bank write, swap and pulse requests.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        acc_next   = acc;
        tmo_next   = tmo;
        done_next  = 1'b0;
        err_next   = 1'b0;
        wr_en      = 1'b0;
        swap       = 1'b0;

        case (state)
            IDLE: begin
                tmo_next = '0;
                if (accept && in_data == HEADER) begin
                    state_next = LOAD;
                    idx_next   = '0;
                    acc_next   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    // A HEADER value here is just data: no mid-frame resync.
                    wr_en    = 1'b1;
                    acc_next = acc ^ in_data;
                    tmo_next = '0;
                    if (idx == ADDR_BITS'(CUBE_ROWS - 1)) begin
                        state_next = CHECK;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + ADDR_BITS'(1);
                    end
                end else if (tmo_hit) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                    tmo_next   = '0;
                end else begin
                    tmo_next = tmo + 16'd1;
                end
            end
            CHECK: begin
                if (accept) begin
                    tmo_next = '0;
                    if (in_data == acc) begin
                        state_next = COMMIT;
                    end else begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                    tmo_next   = '0;
                end else begin
                    tmo_next = tmo + 16'd1;
                end
            end
            COMMIT: begin
                swap       = 1'b1;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    cube_frame_bank u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_addr    (idx),
        .wr_data    (in_data),
        .wr_en      (wr_en),
        .swap       (swap),
        .frame_cube (frame_cube)
    );

endmodule

// File: tb/tb_cube_frame_loader.sv
// Bench for cube_frame_loader: a frame-level reference model fed by the
// same byte stream, a per-cycle compare process, and directed scenarios
// with hand-computed literal expectations.
module tb_cube_frame_loader;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int         TMO = 20;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] frame_cube [64];
    logic       frame_done;
    logic       frame_err;

    always #5 clk = ~clk;

    cube_frame_loader #(
        .HEADER         (HDR),
        .TIMEOUT_CYCLES (16'(TMO))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .frame_cube (frame_cube),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;   // number of rising edges so far
    int acc_edge    = 0;   // edge at which the last driven byte was taken
    int done_edge   = 0;   // edge that samples the latest frame_done pulse
    int done_cnt    = 0;
    int err_cnt     = 0;
    int nrdy_cnt    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on whole frames: collect bytes after a header, XOR the 64 data
    // bytes when the 65th arrives, and schedule the visible effects.
    logic [7:0] m_front [64];
    logic [7:0] m_next  [64];
    logic [7:0] m_buf [$];
    bit         m_in_frame = 0;
    bit         m_commit   = 0;
    bit         m_ready    = 0;
    bit         m_done     = 0;
    bit         m_err      = 0;
    int         m_idle     = 0;

    always @(posedge clk) begin
        logic [7:0] x;
        m_done = 0;
        m_err  = 0;
        if (rst) begin
            for (int i = 0; i < 64; i++) m_front[i] = 8'h00;
            m_in_frame = 0;
            m_commit   = 0;
            m_ready    = 1;
            m_idle     = 0;
            m_buf.delete();
        end else if (m_commit) begin
            for (int i = 0; i < 64; i++) m_front[i] = m_next[i];
            m_commit = 0;
            m_ready  = 1;
            m_done   = 1;
        end else if (in_valid && m_ready) begin
            if (!m_in_frame) begin
                if (in_data == HDR) begin
                    m_in_frame = 1;
                    m_idle     = 0;
                    m_buf.delete();
                end
            end else if (m_buf.size() < 64) begin
                m_buf.push_back(in_data);
                m_idle = 0;
            end else begin
                x = 8'h00;
                foreach (m_buf[k]) x ^= m_buf[k];
                if (x == in_data) begin
                    for (int i = 0; i < 64; i++) m_next[i] = m_buf[i];
                    m_commit = 1;
                    m_ready  = 0;
                end else begin
                    m_err = 1;
                end
                m_in_frame = 0;
            end
        end else if (m_in_frame) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_err      = 1;
                m_in_frame = 0;
            end
        end
    end

    // ---------------- scoreboard: per-cycle compare ----------------
    always @(negedge clk) begin
        int bad;
        chk_int("in_ready", int'(in_ready), int'(m_ready && !rst));
        chk_int("frame_done", int'(frame_done), int'(m_done));
        chk_int("frame_err", int'(frame_err), int'(m_err));
        bad = -1;
        for (int i = 0; i < 64; i++) begin
            if (bad < 0 && frame_cube[i] !== m_front[i]) bad = i;
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL frame_cube[%0d]: got %02h expected %02h (t=%0t)",
                     bad, frame_cube[bad], m_front[bad], $time);
        end
        if (frame_done) begin
            done_cnt++;
            done_edge = cyc + 1;
        end
        if (frame_err) err_cnt++;
        if (!in_ready && !rst) nrdy_cnt++;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [7:0] pat(input int kind, input int i);
        int t;
        case (kind)
            0:       t = i;
            1:       t = i * 3 + 7;
            default: t = 255 - i;
        endcase
        return 8'(t);
    endfunction

    // Present one byte (in_valid stays high afterwards) until it is taken.
    task automatic send_byte(input logic [7:0] b);
        int  guard;
        bit  ok;
        guard    = 0;
        ok       = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 20);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: byte %02h not accepted in %0d cycles", b, guard);
        end
        acc_edge = cyc;
    endtask

    task automatic send_frame(input int kind, input logic [7:0] flip);
        logic [7:0] cs;
        logic [7:0] d;
        cs = 8'h00;
        send_byte(HDR);
        for (int i = 0; i < 64; i++) begin
            d  = pat(kind, i);
            cs = cs ^ d;
            send_byte(d);
        end
        send_byte(cs ^ flip);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int cs_edge;
        int n0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_int("reset_in_ready", int'(in_ready), 0);
        chk_int("reset_row0", int'(frame_cube[0]), 0);
        chk_int("reset_row63", int'(frame_cube[63]), 0);
        rst = 1'b0;
        idle(2);

        // bytes 00..3F, checksum 00
        send_frame(0, 8'h00);
        cs_edge = acc_edge;
        idle(4);
        chk_int("latency_done", done_edge - cs_edge, 2);
        chk_int("done_cnt_a", done_cnt, 1);
        for (int i = 0; i < 64; i++) chk_int("ramp_row", int'(frame_cube[i]), i);

        // same frame, checksum 01
        send_frame(0, 8'h01);
        idle(4);
        chk_int("bad_cs_err", err_cnt, 1);
        chk_int("bad_cs_no_done", done_cnt, 1);
        chk_int("bad_cs_row40", int'(frame_cube[40]), 40);

        // junk before the header
        send_byte(8'h00);
        send_byte(8'h7E);
        send_frame(1, 8'h00);
        idle(4);
        chk_int("junk_done", done_cnt, 2);
        chk_int("junk_row5", int'(frame_cube[5]), 22);
        chk_int("junk_row63", int'(frame_cube[63]), 196);
        chk_int("junk_no_err", err_cnt, 1);

        // stall mid-frame
        send_byte(HDR);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
        idle(TMO - 2);
        chk_int("tmo_not_yet", err_cnt, 1);
        idle(7);
        chk_int("tmo_err", err_cnt, 2);
        send_frame(2, 8'h00);
        idle(4);
        chk_int("tmo_recover_done", done_cnt, 3);
        chk_int("tmo_recover_row0", int'(frame_cube[0]), 255);

        // reset mid-frame
        send_byte(HDR);
        for (int i = 0; i < 30; i++) send_byte(8'(i + 9));
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk_int("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk_int("midrst_row0", int'(frame_cube[0]), 0);
        chk_int("midrst_row9", int'(frame_cube[9]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        chk_int("midrst_no_err", err_cnt, 2);
        send_frame(1, 8'h00);
        idle(4);
        chk_int("midrst_done", done_cnt, 4);
        chk_int("midrst_row10", int'(frame_cube[10]), 37);

        // two frames back to back with in_valid held high
        n0 = nrdy_cnt;
        send_frame(0, 8'h00);
        send_frame(2, 8'h00);
        idle(4);
        chk_int("b2b_nrdy", nrdy_cnt - n0, 2);
        chk_int("b2b_done", done_cnt, 6);
        chk_int("b2b_row0", int'(frame_cube[0]), 255);
        chk_int("b2b_row63", int'(frame_cube[63]), 192);
        chk_int("b2b_no_err", err_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
